// File: rtl/instr_encoder_if.sv
// Request/handshake and instruction-memory write bundle for instr_encoder.
// The master side issues symbolic requests; the slave side assembles and writes words.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op_sel;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [5:0]            funct;
  logic [15:0]           imm;
  logic [25:0]           target;
  logic                  rewind;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wd;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output in_valid, op_sel, rs, rt, rd, funct, imm, target, rewind,
    input  in_ready, imem_we, imem_addr, imem_wd, full, count
  );

  modport slave (
    input  in_valid, op_sel, rs, rt, rd, funct, imm, target, rewind,
    output in_ready, imem_we, imem_addr, imem_wd, full, count
  );
endinterface

// File: rtl/instr_encoder.sv
// Assembles MIPS instruction words from symbolic requests and writes them
// sequentially into instruction memory, one word per two cycles.
module instr_encoder #(
  parameter int ADDR_WIDTH = 6
) (
  input logic            clk,
  input logic            reset,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, FULL} stateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BBT   = 6'b111111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_CMP   = 6'b111110;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  stateT                 state, stateNext;
  logic [ADDR_WIDTH-1:0] ptr, ptrNext, addrReg;
  logic [ADDR_WIDTH:0]   cnt, cntNext;
  logic [31:0]           wordReg, encWord;
  logic                  capture;

  always_comb begin
    encWord = '0;
    case (bus.op_sel)
      3'd0: encWord = {OP_RTYPE, bus.rs, bus.rt, bus.rd, 5'b0, bus.funct};
      3'd1: encWord = {OP_LW,    bus.rs, bus.rt, bus.imm};
      3'd2: encWord = {OP_SW,    bus.rs, bus.rt, bus.imm};
      3'd3: encWord = {OP_BEQ,   bus.rs, bus.rt, bus.imm};
      3'd4: encWord = {OP_BBT,   bus.rs, bus.rt, bus.imm};
      3'd5: encWord = {OP_ADDI,  bus.rs, bus.rt, bus.imm};
      3'd6: encWord = {OP_J,     bus.target};
      3'd7: encWord = {OP_CMP,   bus.rs, bus.rt, bus.rd, 5'b0, bus.funct};
    endcase
  end

  // Rewind beats a new request in IDLE/FULL, but never cancels a write already in flight.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    cntNext   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rewind) begin
          ptrNext = '0;
          cntNext = '0;
        end else if (bus.in_valid) begin
          capture   = 1'b1;
          stateNext = WRITE;
        end
      end
      WRITE: begin
        ptrNext = ptr + PTR_ONE;
        cntNext = cnt + CNT_ONE;
        if (bus.rewind) begin
          ptrNext   = '0;
          cntNext   = '0;
          stateNext = IDLE;
        end else if (ptr == PTR_LAST) begin
          stateNext = FULL;
        end else begin
          stateNext = IDLE;
        end
      end
      FULL: begin
        if (bus.rewind) begin
          ptrNext   = '0;
          cntNext   = '0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // The address register latches at accept so the write port holds its value between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      wordReg <= '0;
      addrReg <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
      cnt   <= cntNext;
      if (capture) begin
        wordReg <= encWord;
        addrReg <= ptr;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.imem_we   = (state == WRITE) && !reset;
  assign bus.imem_addr = addrReg;
  assign bus.imem_wd   = wordReg;
  assign bus.full      = (state == FULL);
  assign bus.count     = cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a 64-word instance for encoding and
// pointer behaviour, and a 4-word instance for the full/rewind corner cases.
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        valid6, valid2, rewind6, rewind2;
  logic [2:0]  opSel;
  logic [4:0]  rsF, rtF, rdF;
  logic [5:0]  functF;
  logic [15:0] immF;
  logic [25:0] targetF;

  int checks;
  int errors;
  int weCount6;
  int weCount2;

  logic [31:0] expWord [8] = '{32'h03FFF83F, 32'h8FFFFFFF, 32'hAFFFFFFF, 32'h13FFFFFF,
                               32'hFFFFFFFF, 32'h23FFFFFF, 32'h0BFFFFFF, 32'hFBFFF83F};
  logic [5:0]  expOp   [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                               6'b111111, 6'b001000, 6'b000010, 6'b111110};

  instr_encoder_if #(.ADDR_WIDTH(6)) bus6 ();
  instr_encoder_if #(.ADDR_WIDTH(2)) bus2 ();

  instr_encoder #(.ADDR_WIDTH(6)) u6 (.clk(clk), .reset(reset), .bus(bus6));
  instr_encoder #(.ADDR_WIDTH(2)) u2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus6.in_valid = valid6;
  assign bus6.rewind   = rewind6;
  assign bus6.op_sel   = opSel;
  assign bus6.rs       = rsF;
  assign bus6.rt       = rtF;
  assign bus6.rd       = rdF;
  assign bus6.funct    = functF;
  assign bus6.imm      = immF;
  assign bus6.target   = targetF;

  assign bus2.in_valid = valid2;
  assign bus2.rewind   = rewind2;
  assign bus2.op_sel   = opSel;
  assign bus2.rs       = rsF;
  assign bus2.rt       = rtF;
  assign bus2.rd       = rdF;
  assign bus2.funct    = functF;
  assign bus2.imm      = immF;
  assign bus2.target   = targetF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus6.imem_we) weCount6++;
    if (bus2.imem_we) weCount2++;
  end

  // Presents one request for a single cycle; returns at the negedge of the WRITE cycle.
  task automatic applyStimulus(input int which, input logic [2:0] o, input logic [4:0] s,
                               input logic [4:0] t, input logic [4:0] d, input logic [5:0] f,
                               input logic [15:0] i, input logic [25:0] tg);
    @(negedge clk);
    opSel = o; rsF = s; rtF = t; rdF = d; functF = f; immF = i; targetF = tg;
    if (which == 6) valid6 = 1'b1;
    else            valid2 = 1'b1;
    @(negedge clk);
    valid6 = 1'b0;
    valid2 = 1'b0;
  endtask

  task automatic pulseRewind(input int which);
    @(negedge clk);
    if (which == 6) rewind6 = 1'b1;
    else            rewind2 = 1'b1;
    @(negedge clk);
    rewind6 = 1'b0;
    rewind2 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus6.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready got %b exp 0", bus6.in_ready);
    end
    checks++;
    if (bus6.imem_we !== 1'b0 || bus6.count !== 7'd0 || bus6.full !== 1'b0 ||
        bus6.imem_addr !== 6'd0 || bus6.imem_wd !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got we=%b cnt=%0d full=%b addr=%0d wd=%h exp 0/0/0/0/0",
               bus6.imem_we, bus6.count, bus6.full, bus6.imem_addr, bus6.imem_wd);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus6.in_ready !== 1'b1 || bus2.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL post_reset_ready got %b/%b exp 1/1", bus6.in_ready, bus2.in_ready);
    end
  endtask

  task automatic test_single;
    applyStimulus(6, 3'd1, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0);
    checks++;
    if (bus6.imem_we !== 1'b1 || bus6.imem_addr !== 6'd0 || bus6.imem_wd !== 32'h8FA80004) begin
      errors++;
      $display("[TB] FAIL lw_write got we=%b addr=%0d wd=%h exp 1/0/8fa80004",
               bus6.imem_we, bus6.imem_addr, bus6.imem_wd);
    end
    checks++;
    if (bus6.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL lw_ready_in_write got %b exp 0", bus6.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus6.imem_we !== 1'b0 || bus6.in_ready !== 1'b1 || bus6.count !== 7'd1 ||
        bus6.imem_wd !== 32'h8FA80004) begin
      errors++;
      $display("[TB] FAIL lw_after got we=%b rdy=%b cnt=%0d wd=%h exp 0/1/1/8fa80004",
               bus6.imem_we, bus6.in_ready, bus6.count, bus6.imem_wd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [4] = '{32'h02328020, 32'h08000010, 32'h1100FFFF, 32'h20080005};
    int startWe;
    pulseRewind(6);
    startWe = weCount6;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: applyStimulus(6, 3'd0, 5'd17, 5'd18, 5'd16, 6'h20, 16'h0, 26'h0);
        1: applyStimulus(6, 3'd6, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010);
        2: applyStimulus(6, 3'd3, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
        default: applyStimulus(6, 3'd5, 5'd0, 5'd8, 5'd0, 6'h0, 16'h0005, 26'h0);
      endcase
      checks++;
      if (bus6.imem_we !== 1'b1 || bus6.imem_addr !== k[5:0] || bus6.imem_wd !== exp[k]) begin
        errors++;
        $display("[TB] FAIL b2b_word%0d got we=%b addr=%0d wd=%h exp 1/%0d/%h",
                 k, bus6.imem_we, bus6.imem_addr, bus6.imem_wd, k, exp[k]);
      end
    end
    @(negedge clk);
    checks++;
    if ((weCount6 - startWe) != 4 || bus6.count !== 7'd4) begin
      errors++;
      $display("[TB] FAIL b2b_pulses got pulses=%0d cnt=%0d exp 4/4", weCount6 - startWe, bus6.count);
    end
  endtask

  task automatic test_opcodes;
    logic [2:0] o;
    for (int k = 0; k < 8; k++) begin
      o = k[2:0];
      applyStimulus(6, o, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h3FFFFFF);
      checks++;
      if (bus6.imem_wd[31:26] !== expOp[k] || bus6.imem_wd !== expWord[k]) begin
        errors++;
        $display("[TB] FAIL opcode_sel%0d got %h exp %h", k, bus6.imem_wd, expWord[k]);
      end
      if (k == 0 || k == 7) begin
        checks++;
        if (bus6.imem_wd[10:6] !== 5'b0) begin
          errors++;
          $display("[TB] FAIL shamt_zero_sel%0d got %b exp 00000", k, bus6.imem_wd[10:6]);
        end
      end
    end
  endtask

  task automatic test_full;
    int startWe;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2, 3'd5, 5'd0, 5'd1, 5'd0, 6'd0, 16'(k), 26'd0);
      checks++;
      if (bus2.imem_we !== 1'b1 || bus2.imem_addr !== k[1:0] || bus2.imem_wd !== (32'h20010000 | k)) begin
        errors++;
        $display("[TB] FAIL fill_addr%0d got we=%b addr=%0d wd=%h exp 1/%0d", k,
                 bus2.imem_we, bus2.imem_addr, bus2.imem_wd, k);
      end
    end
    @(negedge clk);
    checks++;
    if (bus2.full !== 1'b1 || bus2.in_ready !== 1'b0 || bus2.count !== 3'd4) begin
      errors++;
      $display("[TB] FAIL full_flag got full=%b rdy=%b cnt=%0d exp 1/0/4",
               bus2.full, bus2.in_ready, bus2.count);
    end
    startWe = weCount2;
    valid2 = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ((weCount2 - startWe) != 0 || bus2.full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_blocks got pulses=%0d full=%b exp 0/1", weCount2 - startWe, bus2.full);
    end
    rewind2 = 1'b1;
    @(negedge clk);
    rewind2 = 1'b0;
    valid2  = 1'b0;
    #1;
    checks++;
    if (bus2.full !== 1'b0 || bus2.count !== 3'd0 || bus2.in_ready !== 1'b1 ||
        (weCount2 - startWe) != 0) begin
      errors++;
      $display("[TB] FAIL full_rewind got full=%b cnt=%0d rdy=%b pulses=%0d exp 0/0/1/0",
               bus2.full, bus2.count, bus2.in_ready, weCount2 - startWe);
    end
    applyStimulus(2, 3'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0010, 26'd0);
    checks++;
    if (bus2.imem_we !== 1'b1 || bus2.imem_addr !== 2'd0 || bus2.imem_wd !== 32'h8C430010) begin
      errors++;
      $display("[TB] FAIL refill_addr0 got we=%b addr=%0d wd=%h exp 1/0/8c430010",
               bus2.imem_we, bus2.imem_addr, bus2.imem_wd);
    end
  endtask

  task automatic test_rewind_in_write;
    pulseRewind(6);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6, 3'd2, 5'd4, 5'd5, 5'd0, 6'd0, 16'(k), 26'd0);
      if (k == 2) rewind6 = 1'b1;
      checks++;
      if (bus6.imem_we !== 1'b1 || bus6.imem_addr !== k[5:0]) begin
        errors++;
        $display("[TB] FAIL rw_addr%0d got we=%b addr=%0d exp 1/%0d", k, bus6.imem_we, bus6.imem_addr, k);
      end
    end
    @(negedge clk);
    rewind6 = 1'b0;
    checks++;
    if (bus6.count !== 7'd0 || bus6.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rw_cleared got cnt=%0d rdy=%b exp 0/1", bus6.count, bus6.in_ready);
    end
    applyStimulus(6, 3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'h1234, 26'd0);
    checks++;
    if (bus6.imem_addr !== 6'd0 || bus6.imem_wd !== 32'hFC221234) begin
      errors++;
      $display("[TB] FAIL rw_next_addr got addr=%0d wd=%h exp 0/fc221234", bus6.imem_addr, bus6.imem_wd);
    end
    @(negedge clk);
    checks++;
    if (bus6.count !== 7'd1) begin
      errors++; $display("[TB] FAIL rw_count got %0d exp 1", bus6.count);
    end
  endtask

  task automatic test_reset_in_write;
    int startWe;
    applyStimulus(6, 3'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0);
    startWe = weCount6;
    reset = 1'b1;
    #1;
    checks++;
    if (bus6.imem_we !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_abort_we got %b exp 0", bus6.imem_we);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus6.count !== 7'd0 || bus6.in_ready !== 1'b1 || bus6.imem_addr !== 6'd0 ||
        (weCount6 - startWe) != 0) begin
      errors++;
      $display("[TB] FAIL rst_abort_state got cnt=%0d rdy=%b addr=%0d pulses=%0d exp 0/1/0/0",
               bus6.count, bus6.in_ready, bus6.imem_addr, weCount6 - startWe);
    end
    applyStimulus(6, 3'd7, 5'd3, 5'd4, 5'd5, 6'h2A, 16'd0, 26'd0);
    checks++;
    if (bus6.imem_we !== 1'b1 || bus6.imem_addr !== 6'd0 || bus6.imem_wd !== 32'hF864282A) begin
      errors++;
      $display("[TB] FAIL rst_next_addr got we=%b addr=%0d wd=%h exp 1/0/f864282a",
               bus6.imem_we, bus6.imem_addr, bus6.imem_wd);
    end
  endtask

  initial begin
    checks = 0; errors = 0; weCount6 = 0; weCount2 = 0;
    valid6 = 1'b0; valid2 = 1'b0; rewind6 = 1'b0; rewind2 = 1'b0;
    opSel = '0; rsF = '0; rtF = '0; rdF = '0; functF = '0; immF = '0; targetF = '0;
    test_reset;
    test_single;
    test_back_to_back;
    test_opcodes;
    test_full;
    test_rewind_in_write;
    test_reset_in_write;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Encoder counterpart to the main control decoder. Accepts symbolic instruction requests (operation class plus register and immediate fields) over a valid/ready handshake and assembles 32-bit MIPS instruction words. The decoder's opcode set is the contract: every word this block emits decodes to the intended control bundle. Words are written sequentially into instruction memory through a simple write port, for bench program loading and self-test image generation.

Parameters:
ADDR_WIDTH, 6, word-address width of the instruction memory write port; depth = 2^ADDR_WIDTH words.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
op_sel  input  3  0=R-type, 1=LW, 2=SW, 3=BEQ, 4=BBT, 5=ADDI, 6=J, 7=CMP
rs  input  5  source register field
rt  input  5  second source / target register field
rd  input  5  destination register field (R-type, CMP only)
funct  input  6  function field (R-type, CMP only)
imm  input  16  immediate / branch offset
target  input  26  jump target field
rewind  input  1  reset write pointer to 0
imem_we  output  1  instruction memory write enable
imem_addr  output  ADDR_WIDTH  word address of the write
imem_wd  output  32  encoded instruction word
full  output  1  memory image full; no further accepts
count  output  ADDR_WIDTH+1  number of words written since reset/rewind

Behaviour:
- Opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, BBT 111111, ADDI 001000, J 000010, CMP 111110.
- R-type, CMP: {op, rs, rt, rd, 5'b0, funct}. LW, SW, BEQ, BBT, ADDI: {op, rs, rt, imm}. J: {op, target}. Fields not used by the selected format are ignored.
- FSM states: IDLE, WRITE, FULL.
- IDLE: in_ready=1. On in_valid, capture the encoded word into a register and go to WRITE. in_ready is a function of state only; it has no combinational path from in_valid.
- WRITE: in_ready=0, imem_we=1, imem_addr=ptr, imem_wd=captured word, for exactly one cycle. Next edge: ptr+1, count+1. If ptr was 2^ADDR_WIDTH-1, go to FULL; otherwise go to IDLE.
- Latency: the write occurs in the cycle after the accept. Throughput: one word per 2 cycles.
- FULL: full=1, in_ready=0, imem_we=0. ptr has wrapped to 0 and count = 2^ADDR_WIDTH. Stays in FULL until rewind or reset.
- rewind in IDLE or FULL: ptr=0, count=0, full=0, next state IDLE. In that cycle, rewind overrides in_valid; no accept occurs.
- rewind in WRITE: the current write completes at the current ptr. Then ptr=0, count=0, and the next state is IDLE, even if the write was to the last address.
- imem_addr and imem_wd hold their last values when imem_we=0. Consumers must qualify them with imem_we.
- Reset: state=IDLE, ptr=0, count=0, full=0, imem_we=0, imem_addr=0, imem_wd=0, in_ready=0 during reset and 1 in the first cycle after.
- Reset in WRITE aborts the pending write (imem_we=0 that cycle) and takes priority over rewind.

Test Plan:
- Reset, then accept op_sel=1 (LW), rs=29, rt=8, imm=0x0004 -> one cycle later imem_we=1, imem_addr=0, imem_wd=0x8FA80004; count=1; in_ready=0 during WRITE, then 1.
- Back-to-back accepts: R-type rs=17, rt=18, rd=16, funct=0x20 -> 0x02328020 at addr 0. J target=0x0000010 -> 0x08000010 at addr 1. BEQ rs=8, rt=0, imm=0xFFFF -> 0x1100FFFF at addr 2. ADDI rs=0, rt=8, imm=5 -> 0x20080005 at addr 3. Check exactly one imem_we pulse per accept.
- Opcode coverage: every op_sel 0..7 with fields all-ones -> the top 6 bits of the word match the opcode list; R-type and CMP have bits[10:6]=0.
- ADDR_WIDTH=2: four accepts -> addresses 0,1,2,3, then full=1, in_ready=0, count=4. Hold in_valid=1 for 10 cycles -> no imem_we. Pulse rewind -> full=0, count=0; the next accept writes addr 0.
- rewind asserted during WRITE at addr 2 -> the write to addr 2 occurs; the next accepted word goes to addr 0; count=1 after that write.
- reset asserted in the WRITE cycle -> imem_we stays 0, count=0; the next accept writes addr 0.
